seq_alu: RTL

Multi-cycle, parameterised successor to the single-cycle datapath ALU. Executes the existing eight logic/arithmetic operations plus unsigned multiply and unsigned divide behind a start/done handshake, with registered results. Sits in the execute stage of the multi-cycle CPU. The control unit holds the stage while `busy` is high.

---
 rtl/seq_alu.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: eight single-cycle logic/arithmetic ops plus iterative MULU/DIVU behind start/done.
// Define SEQ_ALU_DIV_EN to build the restoring divider; without it op 9 reports illegal.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       ALUOp,
    input  logic             ALUSrcB,
    input  logic [WIDTH-1:0] inputData1,
    input  logic [WIDTH-1:0] inputData2,
    input  logic [WIDTH-1:0] extendInputData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             zero,
    output logic             illegal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] quick;
    logic             quick_ill;
    logic             iter_op;
`ifdef SEQ_ALU_DIV_EN
    logic             is_div;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
`endif

    always_comb begin
        opb = ALUSrcB ? extendInputData : inputData2;
`ifdef SEQ_ALU_DIV_EN
        iter_op = (ALUOp == 4'd8) || (ALUOp == 4'd9);
`else
        iter_op = (ALUOp == 4'd8);
`endif
    end

    always_comb begin
        quick     = '0;
        quick_ill = 1'b0;
        case (ALUOp)
            4'd0:    quick = inputData1 + opb;
            4'd1:    quick = inputData1 - opb;
            4'd2:    quick = opb - inputData1;
            4'd3:    quick = inputData1 | opb;
            4'd4:    quick = inputData1 & opb;
            4'd5:    quick = ~inputData1 & opb;
            4'd6:    quick = inputData1 ^ opb;
            4'd7:    quick = inputData1 ~^ opb;
            default: quick_ill = 1'b1;
        endcase
    end

    // {hi,lo} is shared: multiplier shifts right (product builds from the top),
    // divider shifts left (remainder in hi, quotient bits enter lo from the bottom).
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
        hi_nxt  = mul_sum[WIDTH:1];
        lo_nxt  = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        div_shift = {hi, lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_reg};
        div_diff  = div_shift[WIDTH-1:0] - b_reg;
        if (is_div) begin
            hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            b_reg    <= '0;
            result   <= '0;
            resultHi <= '0;
            zero     <= 1'b1;
            illegal  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            is_div   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (iter_op) begin
                            hi    <= '0;
                            lo    <= inputData1;
                            b_reg <= opb;
                            cnt   <= CNT_W'(WIDTH);
`ifdef SEQ_ALU_DIV_EN
                            is_div <= (ALUOp == 4'd9);
`endif
                            state <= S_ITER;
                        end else begin
                            result   <= quick;
                            resultHi <= '0;
                            zero     <= (quick == '0);
                            illegal  <= quick_ill;
                            state    <= S_DONE;
                        end
                    end
                end
                S_ITER: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result   <= lo_nxt;
                        resultHi <= hi_nxt;
                        zero     <= (lo_nxt == '0);
                        illegal  <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == S_ITER);
        done = (state == S_DONE);
    end

endmodule
